// File: rtl/square_drawer_if.sv
// Square-drawer handshake bundle.
//   start/x_loc/y_loc : move request from the square-location picker.
//   wr_ready          : frame-buffer writer accepts the current pixel write.
//   wr_en/pixel_*     : one pixel write per cycle towards the frame buffer.
//   busy/done         : draw status back to the game controller.
// The master modport is the surrounding system (picker + frame buffer); the
// slave modport is the drawer itself.
interface square_drawer_if;
  logic        start;
  logic [10:0] x_loc;
  logic [10:0] y_loc;
  logic        wr_ready;
  logic        wr_en;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        pixel_color;
  logic        busy;
  logic        done;

  modport master (
    output start, x_loc, y_loc, wr_ready,
    input  wr_en, pixel_x, pixel_y, pixel_color, busy, done
  );

  modport slave (
    input  start, x_loc, y_loc, wr_ready,
    output wr_en, pixel_x, pixel_y, pixel_color, busy, done
  );
endinterface

// File: rtl/square_drawer.sv
// Square drawer: on an accepted start, erases the previously drawn SIZE x SIZE
// square (background writes) and draws the new one (foreground writes), one
// pixel per cycle, row-major, clipping anything outside the visible screen.
// Ports:
//   clk   : system clock.
//   reset : asynchronous active-low reset.
//   sq    : square_drawer_if.slave (start/x_loc/y_loc in, wr_ready in,
//           wr_en/pixel_x/pixel_y/pixel_color/busy/done out, all registered).
module square_drawer #(
  parameter int unsigned SIZE     = 20,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input logic            clk,
  input logic            reset,
  square_drawer_if.slave sq
);

  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] LastIdx = CW'(SIZE - 1);
  localparam logic [11:0]   ScrW    = 12'(SCREEN_W);
  localparam logic [11:0]   ScrH    = 12'(SCREEN_H);

  typedef enum logic [1:0] {StIdle, StErase, StDraw, StFin} state_e;

  state_e          state_q, state_d;
  logic            have_prev_q, have_prev_d;
  logic [10:0]     prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic [10:0]     new_x_q, new_x_d, new_y_q, new_y_d;
  // col/row name the next slot to present; last_q marks that the final slot
  // of the phase is the one currently on the outputs.
  logic [CW-1:0]   col_q, col_d, row_q, row_d;
  logic            last_q, last_d;
  logic            wr_en_q, wr_en_d;
  logic [10:0]     px_q, px_d, py_q, py_d;
  logic            color_q, color_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Slot presentation datapath
  logic            pres_draw;
  logic [CW-1:0]   pres_col, pres_row;
  logic [10:0]     base_x, base_y;
  logic [11:0]     sum_x, sum_y;
  logic            in_range;
  logic            slot_free;
  logic            erase_end;

  always_comb begin
    // At the end of the erase phase the first draw slot is presented straight
    // away so the phases run back to back without a bubble.
    erase_end = (state_q == StErase) && last_q;
    pres_draw = (state_q == StDraw) || erase_end;
    pres_col  = erase_end ? '0 : col_q;
    pres_row  = erase_end ? '0 : row_q;
    base_x    = pres_draw ? new_x_q : prev_x_q;
    base_y    = pres_draw ? new_y_q : prev_y_q;
    // 12-bit sums: a square hanging off the far edge never wraps back on screen
    sum_x     = {1'b0, base_x} + 12'(pres_col);
    sum_y     = {1'b0, base_y} + 12'(pres_row);
    in_range  = (sum_x < ScrW) && (sum_y < ScrH);
    // A clipped slot has wr_en low, so it always moves on after one cycle.
    slot_free = !wr_en_q || sq.wr_ready;
  end

  always_comb begin
    state_d     = state_q;
    have_prev_d = have_prev_q;
    prev_x_d    = prev_x_q;
    prev_y_d    = prev_y_q;
    new_x_d     = new_x_q;
    new_y_d     = new_y_q;
    col_d       = col_q;
    row_d       = row_q;
    last_d      = last_q;
    wr_en_d     = wr_en_q;
    px_d        = px_q;
    py_d        = py_q;
    color_d     = color_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // done_q high means we are in the cycle of the done pulse: ignore start
        if (sq.start && !done_q) begin
          new_x_d = sq.x_loc;
          new_y_d = sq.y_loc;
          col_d   = '0;
          row_d   = '0;
          last_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = have_prev_q ? StErase : StDraw;
        end
      end
      StErase, StDraw: begin
        if (slot_free) begin
          if (last_q && (state_q == StDraw)) begin
            wr_en_d = 1'b0;
            state_d = StFin;
          end else begin
            if (erase_end) begin
              state_d = StDraw;
            end
            wr_en_d = in_range;
            color_d = pres_draw;
            // Clipped slots leave the coordinate outputs untouched
            if (in_range) begin
              px_d = sum_x[10:0];
              py_d = sum_y[10:0];
            end
            last_d = (pres_col == LastIdx) && (pres_row == LastIdx);
            if (pres_col == LastIdx) begin
              col_d = '0;
              row_d = pres_row + 1'b1;
            end else begin
              col_d = pres_col + 1'b1;
              row_d = pres_row;
            end
          end
        end
      end
      StFin: begin
        wr_en_d     = 1'b0;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        prev_x_d    = new_x_q;
        prev_y_d    = new_y_q;
        have_prev_d = 1'b1;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      have_prev_q <= 1'b0;
      prev_x_q    <= '0;
      prev_y_q    <= '0;
      new_x_q     <= '0;
      new_y_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      last_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      px_q        <= '0;
      py_q        <= '0;
      color_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      have_prev_q <= have_prev_d;
      prev_x_q    <= prev_x_d;
      prev_y_q    <= prev_y_d;
      new_x_q     <= new_x_d;
      new_y_q     <= new_y_d;
      col_q       <= col_d;
      row_q       <= row_d;
      last_q      <= last_d;
      wr_en_q     <= wr_en_d;
      px_q        <= px_d;
      py_q        <= py_d;
      color_q     <= color_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sq.wr_en       = wr_en_q;
  assign sq.pixel_x     = px_q;
  assign sq.pixel_y     = py_q;
  assign sq.pixel_color = color_q;
  assign sq.busy        = busy_q;
  assign sq.done        = done_q;

endmodule

// File: tb/tb_square_drawer.sv
// Randomized self-checking bench for square_drawer. The reference model lists
// every expected accepted write (erase of the old square, then draw of the new
// one, clipped to the screen) in a queue; a monitor pops it on each accepted
// write.
module tb_square_drawer;
  localparam int Size = 20;
  localparam int ScrW = 640;
  localparam int ScrH = 480;

  logic clk = 1'b0;
  logic reset = 1'b0;

  square_drawer_if sq ();

  square_drawer #(
    .SIZE    (Size),
    .SCREEN_W(ScrW),
    .SCREEN_H(ScrH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sq   (sq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model
  bit          m_have_prev = 1'b0;
  int          m_prev_x = 0;
  int          m_prev_y = 0;
  logic [22:0] exp_q[$];

  task automatic build_exp(input int x, input int y);
    if (m_have_prev) begin
      for (int r = 0; r < Size; r++)
        for (int c = 0; c < Size; c++)
          if (m_prev_x + c < ScrW && m_prev_y + r < ScrH)
            exp_q.push_back({11'(m_prev_x + c), 11'(m_prev_y + r), 1'b0});
    end
    for (int r = 0; r < Size; r++)
      for (int c = 0; c < Size; c++)
        if (x + c < ScrW && y + r < ScrH)
          exp_q.push_back({11'(x + c), 11'(y + r), 1'b1});
  endtask

  // wr_ready driver: 0 = always ready, 1 = random, 2 = pattern 1,0,0,...
  int rdy_mode = 0;
  int rdy_ph = 0;
  initial begin
    sq.wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: sq.wr_ready = 1'b1;
        1: sq.wr_ready = 1'($urandom_range(0, 1));
        default: begin
          sq.wr_ready = (rdy_ph % 3 == 0);
          rdy_ph++;
        end
      endcase
    end
  end

  // Monitor
  bit          mon_en = 1'b0;
  int          n_acc = 0;
  int          n_acc_draw = 0;
  int          n_acc_erase = 0;
  bit          stall_q = 1'b0;
  logic [22:0] stall_pix;
  logic [22:0] mon_cur;
  logic [22:0] mon_exp;

  always @(negedge clk) begin
    if (mon_en && reset) begin
      mon_cur = {sq.pixel_x, sq.pixel_y, sq.pixel_color};
      if (stall_q) check_eq("hold_while_stalled", {8'd0, sq.wr_en, mon_cur}, {8'd0, 1'b1, stall_pix});
      if (sq.wr_en) begin
        check_eq("on_screen", 32'(sq.pixel_x < ScrW && sq.pixel_y < ScrH), 32'd1);
        if (sq.wr_ready) begin
          n_acc++;
          if (sq.pixel_color) n_acc_draw++;
          else n_acc_erase++;
          check_eq("write_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check_eq("write_xyc", {9'd0, mon_cur}, {9'd0, mon_exp});
          end
        end
      end
      stall_q   = sq.wr_en && !sq.wr_ready;
      stall_pix = mon_cur;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic pulse_start(input int x, input int y);
    @(negedge clk);
    sq.start = 1'b1;
    sq.x_loc = 11'(x);
    sq.y_loc = 11'(y);
    @(negedge clk);
    sq.start = 1'b0;
    // Scramble the location inputs: they must not be re-sampled
    sq.x_loc = 11'($urandom);
    sq.y_loc = 11'($urandom);
  endtask

  // One move; poke re-pulses start mid-draw with (5,5), which must be ignored.
  task automatic run_move(input int x, input int y, input bit poke);
    int  busy_cyc, acc0, draw0, erase0, n_exp, phases;
    bit  got_done, first_in;
    busy_cyc = 0;
    got_done = 1'b0;
    phases   = m_have_prev ? 2 : 1;
    first_in = m_have_prev ? (m_prev_x < ScrW && m_prev_y < ScrH) : (x < ScrW && y < ScrH);
    build_exp(x, y);
    n_exp  = exp_q.size();
    acc0   = n_acc;
    draw0  = n_acc_draw;
    erase0 = n_acc_erase;
    pulse_start(x, y);
    // Now one negedge after the start edge
    for (int cyc = 0; cyc < 20000 && !got_done; cyc++) begin
      if (cyc == 0) check_eq("no_write_before_k1", 32'(sq.wr_en), 32'd0);
      if (cyc == 1) check_eq("first_write_latency", 32'(sq.wr_en), 32'(first_in));
      if (sq.done) begin
        got_done = 1'b1;
        check_eq("busy_low_at_done", 32'(sq.busy), 32'd0);
      end else begin
        if (sq.busy) busy_cyc++;
        if (poke && cyc == 60) begin
          sq.start = 1'b1;
          sq.x_loc = 11'd5;
          sq.y_loc = 11'd5;
        end else begin
          sq.start = 1'b0;
        end
        @(negedge clk);
      end
    end
    check_eq("done_seen", 32'(got_done), 32'd1);
    check_eq("all_writes_seen", 32'(exp_q.size()), 32'd0);
    check_eq("write_count", 32'(n_acc - acc0), 32'(n_exp));
    if (rdy_mode == 0) check_eq("busy_cycles", 32'(busy_cyc), 32'(phases * Size * Size + 2));
    // Start coinciding with done must be ignored
    sq.start = 1'b1;
    sq.x_loc = 11'd7;
    sq.y_loc = 11'd7;
    @(negedge clk);
    sq.start = 1'b0;
    check_eq("done_one_cycle", 32'(sq.done), 32'd0);
    @(negedge clk);
    check_eq("start_at_done_ignored", 32'(sq.busy), 32'd0);
    exp_q.delete();
    m_have_prev = 1'b1;
    m_prev_x    = x;
    m_prev_y    = y;
    last_draw   = n_acc_draw - draw0;
    last_erase  = n_acc_erase - erase0;
  endtask

  int last_draw = 0;
  int last_erase = 0;

  initial begin
    sq.start = 1'b0;
    sq.x_loc = '0;
    sq.y_loc = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_wr_en", 32'(sq.wr_en), 32'd0);
    check_eq("rst_busy", 32'(sq.busy), 32'd0);
    check_eq("rst_done", 32'(sq.done), 32'd0);
    check_eq("rst_pixel", {9'd0, sq.pixel_x, sq.pixel_y, sq.pixel_color}, 32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;

    // First draw, then a move with erase
    run_move(100, 50, 1'b0);
    check_eq("first_draw_count", 32'(last_draw), 32'd400);
    check_eq("first_no_erase", 32'(last_erase), 32'd0);
    run_move(600, 400, 1'b0);
    check_eq("move_erase_count", 32'(last_erase), 32'd400);

    // Clipping in the corner
    run_move(620, 470, 1'b0);
    check_eq("clip_draw_count", 32'(last_draw), 32'd200);

    // Stall pattern on wr_ready
    rdy_mode = 2;
    run_move(300, 200, 1'b0);
    check_eq("stall_draw_count", 32'(last_draw), 32'd400);
    rdy_mode = 0;

    // start while busy is ignored; next move's erase proves prev is (40,30)
    run_move(40, 30, 1'b1);
    run_move(200, 100, 1'b0);

    // Asynchronous reset in the middle of the erase of (200,100)
    build_exp(10, 10);
    pulse_start(10, 10);
    repeat (30) @(negedge clk);
    check_eq("pre_reset_wr_en", 32'(sq.wr_en), 32'd1);
    check_eq("pre_reset_color", 32'(sq.pixel_color), 32'd0);
    #1;
    reset = 1'b0;
    #1;
    check_eq("async_rst_wr_en", 32'(sq.wr_en), 32'd0);
    check_eq("async_rst_busy", 32'(sq.busy), 32'd0);
    exp_q.delete();
    m_have_prev = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_move(0, 0, 1'b0);
    check_eq("post_rst_draw", 32'(last_draw), 32'd400);
    check_eq("post_rst_no_erase", 32'(last_erase), 32'd0);

    // Randomized moves, some partly or wholly off screen
    for (int i = 0; i < 5; i++) begin
      rdy_mode = int'($urandom_range(0, 2));
      run_move(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/square_drawer.md
Name: square_drawer

Overview:
- Consumer end of the random square-location interface.
- On a `start` pulse it latches the `x_loc`/`y_loc` produced by the square-location picker.
- It then erases the previously drawn square by writing background pixels over it, and draws the new SIZE x SIZE square by writing foreground pixels.
- Pixel writes go one per cycle to the VGA frame-buffer writer, with a ready/enable handshake.
- Sits between the location picker and the frame-buffer port in the Lab 6 game datapath.

Parameters:
- SIZE, 20: square edge length in pixels (1..64).
- SCREEN_W, 640: visible width; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 480: visible height; pixels with y >= SCREEN_H are clipped.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  one-cycle request to move the square to x_loc/y_loc.
- x_loc  input  11  new square top-left x; sampled only when start is accepted.
- y_loc  input  11  new square top-left y; sampled only when start is accepted.
- wr_ready  input  1  frame-buffer accepts the current write this cycle.
- wr_en  output  1  pixel write request.
- pixel_x  output  11  write x coordinate.
- pixel_y  output  11  write y coordinate.
- pixel_color  output  1  1 = square colour, 0 = background.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse when the draw completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - wr_en, busy, done, pixel_color = 0; pixel_x, pixel_y = 0.
  - have_prev=0; prev_x, prev_y, new_x, new_y, col, row counters = 0.
  - Reset mid-draw aborts immediately; no further writes. The next start performs no erase because have_prev=0.
- States: IDLE, ERASE, DRAW, FIN.
- IDLE:
  - If start=1, latch new_x=x_loc, new_y=y_loc, clear col/row, busy=1.
  - Go to ERASE if have_prev=1, otherwise DRAW.
  - start while busy is ignored, and x_loc/y_loc are not re-sampled.
- ERASE: scans prev_x+col, prev_y+row with pixel_color=0.
- DRAW: scans new_x+col, new_y+row with pixel_color=1.
- Scan order:
  - Row-major: col is the inner loop, 0..SIZE-1; row is the outer loop, 0..SIZE-1.
  - Coordinates use 12-bit internal sums, so there is no wrap-around.
- Per pixel slot:
  - In-range pixel (sum_x < SCREEN_W and sum_y < SCREEN_H): wr_en=1 with registered coordinates. Hold pixel_x, pixel_y, pixel_color and wr_en stable until a cycle with wr_ready=1, then advance.
  - Clipped pixel: wr_en=0 for that slot and advance after one cycle. A clipped slot never waits on wr_ready.
- Phase end:
  - After col=SIZE-1, row=SIZE-1 advances, ERASE goes to DRAW and counters clear.
  - DRAW goes to FIN.
- FIN (one cycle):
  - done=1, wr_en=0, prev_x=new_x, prev_y=new_y, have_prev=1.
  - Next state IDLE; busy drops in the same cycle done is high.
- Latency, with wr_ready held 1 and no clipping:
  - start sampled at edge k; first wr_en is registered-high after edge k+1.
  - Each phase takes SIZE*SIZE cycles.
  - done is high 1 cycle after the last pixel slot.
  - Total start-to-done: first draw = SIZE*SIZE+2 cycles; later draws = 2*SIZE*SIZE+2 cycles.
- A start in the same cycle as done is ignored; it is accepted only in IDLE.
- Outputs are registered; no combinational path from wr_ready or start to any output.

Test Plan:
- Reset, then start with x_loc=100, y_loc=50, wr_ready=1 (SIZE=20):
  - 400 consecutive writes with colour 1, first (100,50), 21st (100,51), last (119,69).
  - No erase writes; done pulses once; busy high 402 cycles.
- Second start at (600,400) after the first completes:
  - 400 colour-0 writes covering (100..119, 50..69), then 400 colour-1 writes (600..619, 400..419), then done.
- Clipping at start (620,470):
  - Writes only for x 620..639, y 470..479: 200 wr_en cycles out of 400 draw slots.
  - No coordinate >= 640 or >= 480 ever appears.
- Stall test: toggle wr_ready 1,0,0,1,... during DRAW:
  - pixel_x/pixel_y/pixel_color hold while wr_ready=0.
  - Every pixel is accepted exactly once, in order; total accepted writes = 400.
- start pulsed again mid-draw with x_loc=5, y_loc=5:
  - Ignored; the draw continues at the original location and prev becomes the original location.
- Assert reset=0 asynchronously mid-ERASE:
  - wr_en and busy go 0 without a clock edge.
  - The next start at (0,0) gives 400 draw writes and no erase.
